// File: rtl/mips_pkg.sv
// Shared definitions for the fetch unit and Control: FSM encodings,
// instruction width and field positions, plus small field-extraction helpers.
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_REQ   = 2'd1,
    F_WAIT  = 2'd2,
    F_ISSUE = 2'd3
  } fetch_state_t;

  function automatic logic [5:0] get_opcode(input logic [INSTR_W-1:0] ir);
    return ir[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [5:0] get_funct(input logic [INSTR_W-1:0] ir);
    return ir[FN_MSB:FN_LSB];
  endfunction

  function automatic logic [4:0] get_rs(input logic [INSTR_W-1:0] ir);
    return ir[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] get_rt(input logic [INSTR_W-1:0] ir);
    return ir[RT_MSB:RT_LSB];
  endfunction

  function automatic logic [4:0] get_rd(input logic [INSTR_W-1:0] ir);
    return ir[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [15:0] get_imm(input logic [INSTR_W-1:0] ir);
    return ir[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: reset load, sequential +4 step, and a word-aligned
// redirect target. All arithmetic wraps modulo 2^PC_W.
module pc_reg #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4
);

  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_next;

  assign pc_plus4 = pc + PC_W'(4);
  // Low two bits of a branch/jump target are dropped to keep fetches word aligned.
  assign target   = redirect_pc & ~PC_W'(3);
  assign pc_next  = redirect ? target : pc_plus4;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch/issue sequencer: fetches a word at the PC, holds it in IR
// and presents decoded fields to Control until it is acknowledged.
//
// state   | meaning
// --------+------------------------------------------------------------
// F_IDLE  | one cycle after reset release, nothing in flight
// F_REQ   | imem_req pulse for the current pc
// F_WAIT  | waiting for imem_rvalid; word captured into IR on that edge
// F_ISSUE | IR valid for Control; pc advances on instr_ack
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [5:0]         Opcode,
  output logic [5:0]         Function,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [15:0]        imm,
  output logic               instr_valid,
  input  logic               instr_ack,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    pc_plus4,
  output logic [1:0]         f_state
);

  fetch_state_t       state;
  fetch_state_t       state_next;
  logic [INSTR_W-1:0] ir;
  logic               ir_load;
  logic               pc_load;
  logic [PC_W-1:0]    pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= F_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      F_IDLE:  state_next = F_REQ;
      F_REQ:   state_next = F_WAIT;
      F_WAIT:  if (imem_rvalid) state_next = F_ISSUE;
      F_ISSUE: if (instr_ack)   state_next = F_REQ;
      default: state_next = F_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    unique case (state)
      F_IDLE:  ;
      F_REQ:   imem_req = 1'b1;
      F_WAIT:  ir_load = imem_rvalid;
      F_ISSUE: begin
        instr_valid = 1'b1;
        pc_load     = instr_ack;
      end
      default: ;
    endcase
  end

  // IR is the only source of the decoded fields, so Control never sees imem_rdata directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir <= '0;
    end else if (ir_load) begin
      ir <= imem_rdata;
    end
  end

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .load_en     (pc_load),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  assign imem_addr = pc;
  assign f_state   = state;

  assign Opcode   = get_opcode(ir);
  assign Function = get_funct(ir);
  assign rs       = get_rs(ir);
  assign rt       = get_rt(ir);
  assign rd       = get_rd(ir);
  assign imm      = get_imm(ir);

endmodule
